// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : program_sequencer
// Brief    : Fetch/execute controller with an internal program memory for the
//            16-bit register-file ALU core. Optional breakpoint support is
//            enabled with the PROGRAM_SEQUENCER_BREAKPOINT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module program_sequencer #(
    parameter int         AW      = 6,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    input  logic          run,
    input  logic          step,
    input  logic          halt_req,
    input  logic          clear,
    input  logic [15:0]   pc_in,
`ifdef PROGRAM_SEQUENCER_BREAKPOINT_EN
    input  logic          bp_en,
    input  logic [AW-1:0] bp_addr,
`endif
    output logic [15:0]   instruction,
    output logic          cpu_en,
    output logic          busy,
    output logic          halted,
    output logic [1:0]    halt_cause,
    output logic [15:0]   instr_count
);

    localparam int         c_DEPTH    = 2**AW;
    localparam logic       c_MODE_RUN = 1'b1;
    localparam logic       c_MODE_STEP = 1'b0;
    localparam logic [1:0] c_CAUSE_NONE = 2'd0;
    localparam logic [1:0] c_CAUSE_OP   = 2'd1;
    localparam logic [1:0] c_CAUSE_PC   = 2'd2;
    localparam logic [1:0] c_CAUSE_EXT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      r_state, w_next_state;
    logic        r_mode, w_next_mode;
    logic [1:0]  r_cause, w_next_cause;
    logic [15:0] r_instr;
    logic [15:0] r_count;
    logic [15:0] r_rdata;
    logic [15:0] r_mem [0:c_DEPTH-1];

    // Synchroniser bit order: {clear, halt_req, step, run}
    logic [3:0]  r_sync1, r_sync2;
    logic [1:0]  r_prev;

    logic w_run_rise, w_step_rise, w_halt_s, w_clear_s;
    logic w_pc_oob, w_bp_hit;
    logic w_mem_rd, w_exec, w_count_clr;

    assign w_run_rise  = r_sync2[0] & ~r_prev[0];
    assign w_step_rise = r_sync2[1] & ~r_prev[1];
    assign w_halt_s    = r_sync2[2];
    assign w_clear_s   = r_sync2[3];
    assign w_pc_oob    = |pc_in[15:AW];

`ifdef PROGRAM_SEQUENCER_BREAKPOINT_EN
    assign w_bp_hit = (r_mode == c_MODE_RUN) && bp_en && (pc_in[AW-1:0] == bp_addr);
`else
    assign w_bp_hit = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_mode  = r_mode;
        w_next_cause = r_cause;
        w_mem_rd     = 1'b0;
        w_exec       = 1'b0;
        w_count_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_count_clr = w_clear_s;
                if (w_run_rise) begin
                    w_next_state = S_FETCH;
                    w_next_mode  = c_MODE_RUN;
                end else if (w_step_rise) begin
                    w_next_state = S_FETCH;
                    w_next_mode  = c_MODE_STEP;
                end
            end
            S_FETCH: begin
                if (w_pc_oob) begin
                    w_next_state = S_HALTED;
                    w_next_cause = c_CAUSE_PC;
                end else if (w_bp_hit) begin
                    w_next_state = S_HALTED;
                    w_next_cause = c_CAUSE_EXT;
                end else begin
                    w_mem_rd     = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                // A halt opcode is swallowed here and never reaches the core.
                if (r_rdata[15:12] == HALT_OP) begin
                    w_next_state = S_HALTED;
                    w_next_cause = c_CAUSE_OP;
                end else begin
                    w_exec = 1'b1;
                    if (r_mode == c_MODE_STEP) begin
                        w_next_state = S_IDLE;
                    end else if (w_halt_s) begin
                        w_next_state = S_HALTED;
                        w_next_cause = c_CAUSE_EXT;
                    end else begin
                        w_next_state = S_FETCH;
                    end
                end
            end
            S_HALTED: begin
                if (w_clear_s) begin
                    w_next_state = S_IDLE;
                    w_next_cause = c_CAUSE_NONE;
                    w_count_clr  = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_mode  <= c_MODE_STEP;
            r_cause <= c_CAUSE_NONE;
            r_instr <= '0;
            r_count <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= {clear, halt_req, step, run};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2[1:0];
            r_state <= w_next_state;
            r_mode  <= w_next_mode;
            r_cause <= w_next_cause;
            if (w_exec) begin
                r_instr <= r_rdata;
            end
            if (w_count_clr) begin
                r_count <= '0;
            end else if (w_exec) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    // Program memory is intentionally not reset.
    always_ff @(posedge clock) begin
        if (r_state == S_IDLE && load_we) begin
            r_mem[load_addr] <= load_data;
        end
        if (w_mem_rd) begin
            r_rdata <= r_mem[pc_in[AW-1:0]];
        end
    end

    // The core samples cpu_en mid-cycle, so the executed word is shown live in EXEC.
    assign instruction = w_exec ? r_rdata : r_instr;
    assign cpu_en      = w_exec;
    assign busy        = (r_state == S_FETCH) || (r_state == S_EXEC);
    assign halted      = (r_state == S_HALTED);
    assign halt_cause  = r_cause;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_sequencer
// Brief    : Self-checking bench for program_sequencer with a core pc model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

    localparam int c_AW    = 6;
    localparam int c_DEPTH = 64;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             load_we = 1'b0;
    logic [c_AW-1:0]  load_addr = '0;
    logic [15:0]      load_data = '0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic             halt_req = 1'b0;
    logic             clear = 1'b0;
    wire  [15:0]      pc_in;
`ifdef PROGRAM_SEQUENCER_BREAKPOINT_EN
    logic             bp_en = 1'b0;
    logic [c_AW-1:0]  bp_addr = '0;
`endif
    logic [15:0]      instruction;
    logic             cpu_en;
    logic             busy;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [15:0]      instr_count;

    int               checks = 0;
    int               errors = 0;
    logic [15:0]      model_mem [0:c_DEPTH-1];
    logic [15:0]      exec_log [0:4095];
    int               n_en = 0;
    int               en_base = 0;
    logic [15:0]      pc_base = '0;
    int               exp_count = 0;

    program_sequencer #(.AW(c_AW), .HALT_OP(4'hF)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .clear       (clear),
        .pc_in       (pc_in),
`ifdef PROGRAM_SEQUENCER_BREAKPOINT_EN
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
`endif
        .instruction (instruction),
        .cpu_en      (cpu_en),
        .busy        (busy),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    // Core model: pc advances by one for every executed instruction.
    assign pc_in = pc_base + 16'(n_en - en_base);

    always @(negedge clock) begin
        if (cpu_en === 1'b1) begin
            exec_log[n_en] = instruction;
            n_en = n_en + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        @(negedge clock);
        load_we = 1'b1; load_addr = a[c_AW-1:0]; load_data = d;
        @(negedge clock);
        load_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic pulse_run();
        @(negedge clock); run = 1'b1;
        repeat (4) @(negedge clock);
        run = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clock); step = 1'b1;
        repeat (4) @(negedge clock);
        step = 1'b0;
    endtask

    task automatic wait_halted(input int budget);
        for (int i = 0; i < budget && halted !== 1'b1; i++) @(negedge clock);
        check("halt_reached", halted, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clock);
        check("busy_drop", busy, 0);
        repeat (3) @(negedge clock);
    endtask

    task automatic do_clear();
        @(negedge clock); clear = 1'b1;
        for (int i = 0; i < 10 && halted !== 1'b0; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        clear = 1'b0;
        repeat (4) @(negedge clock);
        exp_count = 0;
        check("clear_halted", halted, 0);
        check("clear_cause", halt_cause, 0);
        check("clear_count", instr_count, 0);
    endtask

    task automatic start_at(input int pc);
        pc_base = 16'(pc);
        en_base = n_en;
    endtask

    // Reference: the program runs from start until a halt opcode or the end of memory.
    task automatic check_run(input int start);
        int pc = start;
        int k  = 0;
        while (pc < c_DEPTH && model_mem[pc][15:12] != 4'hF) begin
            check("run_instr", exec_log[en_base + k], model_mem[pc]);
            pc++; k++;
        end
        exp_count += k;
        check("run_len", n_en - en_base, k);
        check("run_cause", halt_cause, (pc >= c_DEPTH) ? 2 : 1);
        check("run_count", instr_count, exp_count);
    endtask

    initial begin
        int n;
        logic [15:0] w;

        repeat (3) @(negedge clock);
        check("rst_instr", instruction, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_cause", halt_cause, 0);
        check("rst_count", instr_count, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        for (int a = 0; a < c_DEPTH; a++)
            load_word(a, {4'($urandom_range(0, 14)), 12'($urandom)});
        load_word(0, 16'h0105);
        load_word(1, 16'h0203);
        load_word(2, 16'hF000);
        load_word(5, 16'h1234);

        // Program ending in a halt opcode
        start_at(0);
        pulse_run();
        wait_halted(100);
        check_run(0);
        check("halt_instr_held", instruction, 16'h0203);
        n = n_en;
        pulse_run();
        repeat (10) @(negedge clock);
        check("run_ignored_halted", halted, 1);
        check("run_ignored_en", n_en, n);
        do_clear();

        // Single stepping, one instruction per pulse
        for (int s = 0; s < 3; s++) begin
            start_at(10 + s);
            pulse_step();
            wait_idle(50);
            check("step_en", n_en - en_base, 1);
            check("step_instr", exec_log[en_base], model_mem[10 + s]);
            check("step_halted", halted, 0);
        end
        check("step_count", instr_count, 3);

        // halt_req has no effect in step mode
        halt_req = 1'b1;
        start_at(20);
        pulse_step();
        wait_idle(50);
        check("step_halt_req_en", n_en - en_base, 1);
        check("step_halt_req_halted", halted, 0);
        halt_req = 1'b0;
        repeat (4) @(negedge clock);
        exp_count = 4;

        // pc out of range
        start_at(16'h0040);
        pulse_run();
        wait_halted(50);
        check("oob_en", n_en - en_base, 0);
        check("oob_cause", halt_cause, 2);
        check("oob_count", instr_count, exp_count);
        do_clear();

        // External halt mid-run, with a write attempted while busy
        start_at(20);
        pulse_run();
        repeat (6) @(negedge clock);
        load_we = 1'b1; load_addr = 6'd5; load_data = 16'hBEEF;
        @(negedge clock);
        load_we = 1'b0;
        repeat (4) @(negedge clock);
        halt_req = 1'b1;
        wait_halted(100);
        halt_req = 1'b0;
        n = n_en;
        check("ext_cause", halt_cause, 3);
        for (int k = 0; k < n - en_base; k++)
            check("ext_instr", exec_log[en_base + k], model_mem[20 + k]);
        check("ext_count", instr_count, n - en_base);
        repeat (10) @(negedge clock);
        check("ext_no_more_en", n_en, n);
        do_clear();
        start_at(5);
        pulse_step();
        wait_idle(50);
        check("load_dropped", exec_log[en_base], model_mem[5]);

        // Reset asserted while an instruction executes
        start_at(30);
        @(negedge clock); run = 1'b1;
        for (int i = 0; i < 40 && cpu_en !== 1'b1; i++) @(negedge clock);
        check("pre_reset_en", cpu_en, 1);
        reset = 1'b0;
        run = 1'b0;
        #1;
        check("mid_rst_cpu_en", cpu_en, 0);
        check("mid_rst_instr", instruction, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", instr_count, 0);
        check("mid_rst_cause", halt_cause, 0);
        n = n_en;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        check("post_rst_no_en", n_en, n);
        check("post_rst_halted", halted, 0);
        exp_count = 0;

        // Randomised programs checked against the reference walk
        for (int it = 0; it < 6; it++) begin
            int s;
            int len;
            s   = $urandom_range(0, 50);
            len = $urandom_range(1, 12);
            for (int k = 0; k < len && s + k < c_DEPTH; k++) begin
                w = {4'($urandom_range(0, 14)), 12'($urandom)};
                if (k == len - 1 && $urandom_range(0, 1) == 1) w[15:12] = 4'hF;
                load_word(s + k, w);
            end
            start_at(s);
            pulse_run();
            wait_halted(400);
            check_run(s);
            do_clear();
        end

`ifdef PROGRAM_SEQUENCER_BREAKPOINT_EN
        load_word(0, 16'h0105);
        load_word(1, 16'h0203);
        load_word(2, 16'h3333);
        bp_addr = 6'd2;
        bp_en = 1'b1;
        start_at(0);
        pulse_run();
        wait_halted(100);
        check("bp_en_count", n_en - en_base, 2);
        check("bp_cause", halt_cause, 3);
        do_clear();
        start_at(2);
        pulse_step();
        wait_idle(50);
        check("bp_step_en", n_en - en_base, 1);
        check("bp_step_instr", exec_log[en_base], 16'h3333);
        bp_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Fetch/execute controller for the 16-bit register-file ALU core.
- Holds the program in an internal word-addressed memory, loaded from a write port while idle.
- Presents the instruction addressed by the core's pc and issues a one-cycle cpu_en per executed instruction.
- Provides run, single-step, external-halt and halt-opcode control, plus an executed-instruction counter.

Parameters:
- AW, 6, program memory address width; DEPTH = 2^AW words of 16 bits.
- HALT_OP, 4'hF, opcode (instruction[15:12]) that the sequencer treats as halt; never passed to the core.

Ports:
- clock  in  1  system clock; all sequencer logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- load_we  in  1  program write strobe; honoured only in IDLE.
- load_addr  in  AW  program write address.
- load_data  in  16  program write data.
- run  in  1  level; each rising edge requests free-run.
- step  in  1  level; each rising edge requests one instruction.
- halt_req  in  1  level; stop free-run after the current instruction.
- clear  in  1  level; acknowledges HALTED and clears the counter.
- pc_in  in  16  pc from the core (register 15).
- instruction  out  16  instruction to the core.
- cpu_en  out  1  one-cycle execute enable; the core samples it on its negedge, mid-cycle.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALTED.
- halt_cause  out  2  0 none, 1 halt opcode, 2 pc out of range, 3 external/breakpoint.
- instr_count  out  16  instructions executed, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, instruction=0, cpu_en=0, busy=0, halted=0, halt_cause=0, instr_count=0, mode=STEP.
  - Synchronisers are cleared. Memory contents are not reset.
  - Reset asserted mid-operation aborts immediately; no further cpu_en.
- Input conditioning:
  - run, step, halt_req and clear each pass through a 2-flop synchroniser.
  - run and step are rising-edge detected on the synchronised value.
  - An input rising before edge k is acted on at edge k+2.
- Memory: synchronous write in IDLE only; synchronous read, 1-cycle latency, address pc_in[AW-1:0].
- States:
  - IDLE:
    - run edge -> FETCH with mode=RUN.
    - step edge -> FETCH with mode=STEP.
    - If both edges occur in the same cycle, run wins.
    - load_we writes mem[load_addr]=load_data.
  - FETCH:
    - If pc_in >= DEPTH -> HALTED, cause 2, no read.
    - Otherwise issue the read -> EXEC.
  - EXEC:
    - The read data is checked first.
    - If opcode==HALT_OP -> HALTED, cause 1, cpu_en stays 0, instruction unchanged.
    - Otherwise instruction=data and cpu_en=1 for exactly this cycle, and instr_count increments.
    - Next state: mode=RUN and halt_req(sync)=0 -> FETCH; mode=RUN and halt_req=1 -> HALTED, cause 3; mode=STEP -> IDLE.
  - HALTED:
    - clear(sync)=1 -> IDLE, halt_cause=0, instr_count=0.
    - run and step edges are ignored.
  - clear in IDLE zeroes instr_count; clear is ignored in FETCH and EXEC.
- Timing:
  - With run rising before edge k: FETCH at k+2, EXEC at k+3, first cpu_en during cycle k+3..k+4.
  - Free-run rate is one instruction per 2 clocks.
  - pc_in must be settled by the next FETCH; the core updates pc on the negedge inside EXEC.
- load_we outside IDLE is dropped silently.
- halt_req asserted in IDLE has no effect.
- halt_req in STEP mode has no effect; the step completes to IDLE.

Optional Feature:
- Macro: PROGRAM_SEQUENCER_BREAKPOINT_EN.
- When defined, adds ports bp_en (in, 1) and bp_addr (in, AW).
  - In FETCH with mode=RUN, bp_en=1 and pc_in[AW-1:0]==bp_addr: go to HALTED with cause 3 before execution.
  - STEP mode ignores the breakpoint, so stepping off a breakpoint is possible.
- When undefined, these ports are absent and cause 3 arises only from halt_req.

Test Plan:
- Load mem[0]=16'h0105, mem[1]=16'h0203, mem[2]=16'hF000 in IDLE, pulse run, core model increments pc -> two cpu_en pulses with instruction 0105 then 0203; HALTED, halt_cause=1, instr_count=2.
- After reset, pulse step three times (2+ cycles apart) -> exactly one cpu_en per pulse, busy returns to 0, state IDLE, instr_count=3.
- Run with pc_in forced to 16'h0040 (AW=6) -> no cpu_en, HALTED, halt_cause=2; assert clear -> IDLE, halt_cause=0, instr_count=0.
- Free-run a 20-word NOP-like loop, raise halt_req mid-run -> current EXEC completes with its cpu_en, then HALTED, cause 3, no further cpu_en.
- load_we with addr 5, data 16'hBEEF during RUN -> mem[5] unchanged when read back after halt; reset low during EXEC -> cpu_en=0, all outputs at reset values immediately.
- With BREAKPOINT_EN, bp_addr=2, run from pc 0 -> two cpu_en pulses, HALTED cause 3; clear, step -> instruction at address 2 executes.
